// File: rtl/router_pkg.sv
// router_pkg: shared state encoding and address constants for the 1x3 router control path.
package router_pkg;
  typedef enum logic [2:0] {
    DECODE_ADDRESS     = 3'd0,
    LOAD_FIRST_DATA    = 3'd1,
    LOAD_DATA          = 3'd2,
    LOAD_PARITY        = 3'd3,
    FIFO_FULL_STATE    = 3'd4,
    LOAD_AFTER_FULL    = 3'd5,
    WAIT_TILL_EMPTY    = 3'd6,
    CHECK_PARITY_ERROR = 3'd7
  } fsm_state_t;
  localparam logic [1:0] ADDR_INVALID = 2'b11;
endpackage

// File: rtl/r_fsm.sv
// r_fsm: router packet-control FSM sequencing header, payload and parity loads with busy stall.
module r_fsm
  import router_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_addr,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
);
  fsm_state_t state, nxt;
  logic [1:0] addr;
  logic [3:0] empty_v, srst_v;
  logic       hdr_ok;
  // Bit 3 pads the invalid address so indexing never leaves the vector.
  assign empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
  assign srst_v  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
  assign hdr_ok  = pkt_valid && data_in != ADDR_INVALID;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DECODE_ADDRESS;
      addr  <= 2'd0;
    end else begin
      state <= nxt;
      if (state == DECODE_ADDRESS && hdr_ok) addr <= data_in;
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      DECODE_ADDRESS:     nxt = !hdr_ok ? DECODE_ADDRESS : empty_v[data_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      WAIT_TILL_EMPTY:    nxt = empty_v[addr] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      LOAD_FIRST_DATA:    nxt = LOAD_DATA;
      LOAD_DATA:          nxt = fifo_full ? FIFO_FULL_STATE : !pkt_valid ? LOAD_PARITY : LOAD_DATA;
      FIFO_FULL_STATE:    nxt = fifo_full ? FIFO_FULL_STATE : LOAD_AFTER_FULL;
      LOAD_AFTER_FULL:    nxt = parity_done ? DECODE_ADDRESS : low_pkt_valid ? LOAD_PARITY : LOAD_DATA;
      LOAD_PARITY:        nxt = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: nxt = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      default:            nxt = DECODE_ADDRESS;
    endcase
    if (state != DECODE_ADDRESS && srst_v[addr]) nxt = DECODE_ADDRESS;
  end
  assign detect_addr   = state == DECODE_ADDRESS;
  assign lfd_state     = state == LOAD_FIRST_DATA;
  assign ld_state      = state == LOAD_DATA;
  assign laf_state     = state == LOAD_AFTER_FULL;
  assign full_state    = state == FIFO_FULL_STATE;
  assign rst_int_reg   = state == CHECK_PARITY_ERROR;
  assign write_enb_reg = ld_state || laf_state || state == LOAD_PARITY;
  assign busy          = !(detect_addr || ld_state);
endmodule

// File: tb/tb_r_fsm.sv
// tb_r_fsm: directed plus randomized checking of r_fsm against a packet-phase reference model.
module tb_r_fsm;
  logic clk = 0, rst = 0, pkt_valid = 0, fifo_full = 0;
  logic fifo_empty_0 = 1, fifo_empty_1 = 1, fifo_empty_2 = 1;
  logic soft_reset_0 = 0, soft_reset_1 = 0, soft_reset_2 = 0;
  logic parity_done = 0, low_pkt_valid = 0;
  logic [1:0] data_in = 0;
  logic detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy;
  int n_cmp = 0, n_err = 0;
  int ph = 0;
  logic [1:0] maddr = 0;
  localparam int P_IDLE = 0, P_WAIT = 1, P_HDR = 2, P_BODY = 3, P_PAR = 4, P_FULL = 5, P_AFT = 6, P_CHK = 7;
  r_fsm dut (
    .clk(clk), .rst(rst), .pkt_valid(pkt_valid), .data_in(data_in), .fifo_full(fifo_full),
    .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1), .fifo_empty_2(fifo_empty_2),
    .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2),
    .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_addr(detect_addr), .lfd_state(lfd_state), .ld_state(ld_state), .laf_state(laf_state),
    .full_state(full_state), .rst_int_reg(rst_int_reg), .write_enb_reg(write_enb_reg), .busy(busy)
  );
  always #5 clk = ~clk;
  wire [7:0] obs = {detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy};
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (t=%0t)", tag, got, exp, $time);
    end
  endtask
  // Output pattern {detect,lfd,ld,laf,full,rst_int,we,busy} for each packet phase.
  function automatic logic [7:0] exp_of(input int p);
    case (p)
      P_IDLE:  return 8'b1000_0000;
      P_WAIT:  return 8'b0000_0001;
      P_HDR:   return 8'b0100_0001;
      P_BODY:  return 8'b0010_0010;
      P_PAR:   return 8'b0000_0011;
      P_FULL:  return 8'b0000_1001;
      P_AFT:   return 8'b0001_0011;
      default: return 8'b0000_0101;
    endcase
  endfunction
  task automatic model_step();
    logic [2:0] emp, srs;
    emp = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    srs = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (!rst) begin
      ph = P_IDLE; maddr = 0;
    end else if (ph != P_IDLE && srs[maddr]) ph = P_IDLE;
    else case (ph)
      P_IDLE: if (pkt_valid && data_in != 2'd3) begin maddr = data_in; ph = emp[data_in] ? P_HDR : P_WAIT; end
      P_WAIT: if (emp[maddr]) ph = P_HDR;
      P_HDR:  ph = P_BODY;
      P_BODY: ph = fifo_full ? P_FULL : (!pkt_valid ? P_PAR : P_BODY);
      P_PAR:  ph = P_CHK;
      P_FULL: if (!fifo_full) ph = P_AFT;
      P_AFT:  ph = parity_done ? P_IDLE : (low_pkt_valid ? P_PAR : P_BODY);
      default: ph = fifo_full ? P_FULL : P_IDLE;
    endcase
  endtask
  task automatic cycle(input string tag, input int want);
    @(posedge clk);
    model_step();
    #1;
    chk(tag, obs, exp_of(ph));
    if (want >= 0) chk({tag, "_plan"}, obs, exp_of(want));
  endtask
  task automatic async_reset();
    rst = 0;
    #1;
    ph = P_IDLE; maddr = 0;
    chk("async_rst", obs, exp_of(P_IDLE));
  endtask
  initial begin
    #2;
    chk("reset_hold", obs, 8'b1000_0000);
    cycle("reset_clk", P_IDLE);
    rst = 1;
    cycle("reset_rel", P_IDLE);
    // Normal 4-byte packet to port 1.
    pkt_valid = 1; data_in = 2'd1; fifo_empty_1 = 1;
    cycle("norm_hdr", P_HDR);
    for (int i = 0; i < 3; i++) cycle("norm_ld", P_BODY);
    pkt_valid = 0;
    cycle("norm_par", P_PAR);
    cycle("norm_chk", P_CHK);
    cycle("norm_end", P_IDLE);
    // Non-empty target port 2.
    pkt_valid = 1; data_in = 2'd2; fifo_empty_2 = 0;
    for (int i = 0; i < 5; i++) cycle("wait_busy", P_WAIT);
    fifo_empty_2 = 1;
    cycle("wait_lfd", P_HDR);
    cycle("wait_ld", P_BODY);
    // Full during load, then resume to parity.
    fifo_full = 1;
    for (int i = 0; i < 3; i++) cycle("full_hold", P_FULL);
    fifo_full = 0; low_pkt_valid = 1;
    cycle("full_laf", P_AFT);
    cycle("laf_par", P_PAR);
    cycle("laf_chk", P_CHK);
    cycle("laf_end", P_IDLE);
    // Full again, resume to data.
    data_in = 2'd0; fifo_empty_0 = 1; low_pkt_valid = 0;
    cycle("f2_hdr", P_HDR);
    cycle("f2_ld", P_BODY);
    fifo_full = 1; pkt_valid = 0;
    cycle("full_wins", P_FULL);
    fifo_full = 0;
    cycle("f2_laf", P_AFT);
    pkt_valid = 1;
    cycle("laf_ld", P_BODY);
    pkt_valid = 0;
    cycle("f2_par", P_PAR);
    cycle("f2_chk", P_CHK);
    cycle("f2_end", P_IDLE);
    // Invalid address.
    pkt_valid = 1; data_in = 2'd3;
    cycle("inv_a", P_IDLE);
    cycle("inv_b", P_IDLE);
    // Soft reset on the selected port aborts the packet.
    data_in = 2'd0;
    cycle("sr0_hdr", P_HDR);
    cycle("sr0_ld", P_BODY);
    soft_reset_0 = 1;
    cycle("sr0_abort", P_IDLE);
    soft_reset_0 = 0; pkt_valid = 0;
    cycle("sr0_idle", P_IDLE);
    // Same pulse on a port-1 packet is ignored.
    pkt_valid = 1; data_in = 2'd1;
    cycle("sr1_hdr", P_HDR);
    cycle("sr1_ld", P_BODY);
    soft_reset_0 = 1;
    cycle("sr1_ignore", P_BODY);
    soft_reset_0 = 0; pkt_valid = 0;
    cycle("sr1_par", P_PAR);
    cycle("sr1_chk", P_CHK);
    cycle("sr1_end", P_IDLE);
    // Mid-packet hard reset.
    pkt_valid = 1; data_in = 2'd2;
    cycle("hr_hdr", P_HDR);
    cycle("hr_ld", P_BODY);
    async_reset();
    cycle("hr_held", P_IDLE);
    rst = 1;
    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      pkt_valid     = $urandom_range(0, 9) < 8;
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = $urandom_range(0, 3) == 0;
      fifo_empty_0  = $urandom_range(0, 1) == 1;
      fifo_empty_1  = $urandom_range(0, 1) == 1;
      fifo_empty_2  = $urandom_range(0, 1) == 1;
      soft_reset_0  = $urandom_range(0, 19) == 0;
      soft_reset_1  = $urandom_range(0, 19) == 0;
      soft_reset_2  = $urandom_range(0, 19) == 0;
      parity_done   = $urandom_range(0, 2) == 0;
      low_pkt_valid = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 99) == 0) begin
        async_reset();
        cycle("rnd_rst", P_IDLE);
        rst = 1;
      end else cycle("rnd", -1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
